// File: rtl/bf8b_pkg.sv
// Shared definitions for the bf8b core: op codes, instruction layout,
// decode/issue FSM states and the register-file window base.
package bf8b_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned OP_W    = 2;
  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned DATA_W  = 8;

  localparam logic [OP_W-1:0] OP_NOP   = 2'b00;
  localparam logic [OP_W-1:0] OP_LOAD  = 2'b01;
  localparam logic [OP_W-1:0] OP_STORE = 2'b10;
  localparam logic [OP_W-1:0] OP_ILL   = 2'b11;

  // Instruction field bit positions
  localparam int unsigned OP_HI   = 15;
  localparam int unsigned OP_LO   = 14;
  localparam int unsigned ADDR_HI = 13;
  localparam int unsigned ADDR_LO = 9;
  localparam int unsigned RSV_BIT = 8;
  localparam int unsigned IMM_HI  = 7;
  localparam int unsigned IMM_LO  = 0;

  // Upper address bits of the register window in data memory (0xE0..0xFF)
  localparam logic [2:0] REG_BASE = 3'b111;

  // Instruction word as delivered by fetch (layout matches the positions above)
  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] addr;
    logic              rsv;
    logic [DATA_W-1:0] imm;
  } instr_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_ARM,
    S_WAIT,
    S_DONE
  } state_e;

  // Memory address that execute derives from a register-file address
  function automatic logic [DATA_W-1:0] reg_mem_addr(input logic [ADDR_W-1:0] a);
    return {REG_BASE, a};
  endfunction

endpackage

// File: rtl/decode_issue_timer.sv
// issue_timer: cycle counter with a timeout compare.
// Ports: clk_i/rst_i (sync, active-high), clr_i clears the count,
// en_i advances it by one, expire_c_o is high while count == TIMEOUT-1.
module issue_timer #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_c_o
);

  logic [CNT_W-1:0] cnt_q;

  // Clear has priority so the count never carries across transactions
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign expire_c_o = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/decode_issue.sv
// decode_issue: decode/issue stage of the bf8b core.
// Accepts one instruction per instr_valid/instr_ready handshake, issues
// LOAD/STORE to execute with a one-cycle ex_en pulse, waits for the sticky
// ex_ready, then pulses retire. NOP and illegal ops retire locally.
// Ports: clk, rst (sync, active-high); instr/instr_valid/instr_ready from
// fetch; ex_en/ex_op/ex_val1/ex_val2/ex_addr to execute, ex_ready back;
// retire, busy, illegal (sticky), err_timeout (sticky) status.
module decode_issue
  import bf8b_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [INSTR_W-1:0] instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic              ex_en,
  output logic [OP_W-1:0]   ex_op,
  output logic [DATA_W-1:0] ex_val1,
  output logic [DATA_W-1:0] ex_val2,
  output logic [ADDR_W-1:0] ex_addr,
  input  logic              ex_ready,
  output logic              retire,
  output logic              busy,
  output logic              illegal,
  output logic              err_timeout
);

  state_e            state_q;
  logic              instr_ready_q;
  logic              busy_q;
  logic              ex_en_q;
  logic              retire_q;
  logic              illegal_q;
  logic              err_timeout_q;
  logic [OP_W-1:0]   ex_op_q;
  logic [ADDR_W-1:0] ex_addr_q;
  logic [DATA_W-1:0] ex_val1_q;

  instr_t          ins_c;
  logic [OP_W-1:0] dec_op_c;
  logic            accept_c;
  logic            is_ls_c;
  logic            expire_c;

  // Inline decode; a set reserved bit demotes any op to illegal
  assign ins_c    = instr_t'(instr);
  assign dec_op_c = ins_c.rsv ? OP_ILL : ins_c.op;
  assign is_ls_c  = (dec_op_c == OP_LOAD) || (dec_op_c == OP_STORE);
  assign accept_c = instr_valid && instr_ready_q;

  issue_timer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timer (
    .clk_i      (clk),
    .rst_i      (rst),
    .clr_i      (state_q == S_DONE),
    .en_i       (state_q == S_WAIT),
    .expire_c_o (expire_c)
  );

  // Issue FSM; all status outputs are registered against the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      instr_ready_q <= 1'b0;
      busy_q        <= 1'b0;
      ex_en_q       <= 1'b0;
      retire_q      <= 1'b0;
      illegal_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      ex_op_q       <= '0;
      ex_addr_q     <= '0;
      ex_val1_q     <= '0;
    end else begin
      ex_en_q  <= 1'b0;
      retire_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept_c) begin
            ex_op_q       <= dec_op_c;
            ex_addr_q     <= ins_c.addr;
            ex_val1_q     <= ins_c.imm;
            instr_ready_q <= 1'b0;
            busy_q        <= 1'b1;
            if (is_ls_c) begin
              state_q <= S_ISSUE;
              ex_en_q <= 1'b1;
            end else begin
              state_q <= S_DONE;
              if (dec_op_c == OP_ILL) illegal_q <= 1'b1;
            end
          end else begin
            instr_ready_q <= 1'b1;
            busy_q        <= 1'b0;
          end
        end
        S_ISSUE: state_q <= S_ARM;
        // ex_ready may still be stale from the previous op here, so skip it
        S_ARM:   state_q <= S_WAIT;
        S_WAIT: begin
          if (ex_ready) begin
            state_q <= S_DONE;
          end else if (expire_c) begin
            err_timeout_q <= 1'b1;
            state_q       <= S_DONE;
          end
        end
        S_DONE: begin
          state_q       <= S_IDLE;
          retire_q      <= 1'b1;
          busy_q        <= 1'b0;
          instr_ready_q <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign instr_ready = instr_ready_q;
  assign busy        = busy_q;
  assign ex_en       = ex_en_q;
  assign retire      = retire_q;
  assign illegal     = illegal_q;
  assign err_timeout = err_timeout_q;
  assign ex_op       = ex_op_q;
  assign ex_addr     = ex_addr_q;
  assign ex_val1     = ex_val1_q;
  assign ex_val2     = '0;

endmodule

// File: tb/tb_decode_issue.sv
// Self-checking bench for decode_issue: directed scenarios followed by
// randomized instructions checked against a transaction-level model.
module tb_decode_issue;

  localparam int unsigned TO = 16;

  logic        clk;
  logic        rst;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        ex_en;
  logic [1:0]  ex_op;
  logic [7:0]  ex_val1;
  logic [7:0]  ex_val2;
  logic [4:0]  ex_addr;
  logic        ex_ready;
  logic        retire;
  logic        busy;
  logic        illegal;
  logic        err_timeout;

  decode_issue #(.TIMEOUT(TO), .CNT_W(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .ex_en       (ex_en),
    .ex_op       (ex_op),
    .ex_val1     (ex_val1),
    .ex_val2     (ex_val2),
    .ex_addr     (ex_addr),
    .ex_ready    (ex_ready),
    .retire      (retire),
    .busy        (busy),
    .illegal     (illegal),
    .err_timeout (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_mis = 0;
  int last_en = -100;
  bit ill_seen = 1'b0;
  bit tmo_seen = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Note an ex_en pulse: at least 3 low cycles must separate pulses
  task automatic note_en();
    chk("en_gap_ge4", 32'((cyc - last_en) >= 4), 32'd1);
    last_en = cyc;
  endtask

  // One instruction, accepted in the current cycle (called at a negedge with
  // the decoder idle). rdy = WAIT cycle on which ex_ready first rises.
  task automatic do_op(input logic [15:0] ins, input int rdy, output int lat);
    logic [1:0] op;
    logic [1:0] exp_op;
    bit   is_ls;
    bit   tmo;
    bit   stale;
    bit   done;
    int   k;
    int   exp_lat;
    int   en_cnt;
    int   c;
    op      = ins[15:14];
    is_ls   = (op == 2'b01 || op == 2'b10) && !ins[8];
    exp_op  = ins[8] ? 2'b11 : op;
    tmo     = is_ls && (rdy > int'(TO));
    k       = tmo ? int'(TO) : rdy;
    exp_lat = is_ls ? 4 + k : 2;
    if (!is_ls && exp_op == 2'b11) ill_seen = 1'b1;
    if (tmo) tmo_seen = 1'b1;
    stale  = ex_ready;
    en_cnt = 0;
    c      = 0;
    done   = 1'b0;
    lat    = -1;

    chk("accept_ready", 32'(instr_ready), 32'd1);
    instr       = ins;
    instr_valid = 1'b1;
    while (!done && c < 60) begin
      @(negedge clk);
      c++;
      if (c == 1) begin
        instr_valid = 1'b0;
        instr       = 16'($urandom);
        chk("busy_c1", 32'(busy), 32'd1);
        chk("ready_c1", 32'(instr_ready), 32'd0);
      end
      if (ex_en) begin
        en_cnt++;
        chk("en_cycle", 32'(c), 32'd1);
        chk("en_op", 32'(ex_op), 32'(op));
        chk("en_addr", 32'(ex_addr), 32'(ins[13:9]));
        chk("en_val1", 32'(ex_val1), 32'(ins[7:0]));
        chk("en_val2", 32'(ex_val2), 32'd0);
        note_en();
      end
      if (retire) begin
        done = 1'b1;
        lat  = c;
      end else if (is_ls) begin
        ex_ready = (c <= 2) ? stale : (c >= 2 + rdy);
      end
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("en_pulses", 32'(en_cnt), 32'(is_ls));
    chk("illegal_flag", 32'(illegal), 32'(ill_seen));
    chk("timeout_flag", 32'(err_timeout), 32'(tmo_seen));
    chk("hold_op", 32'(ex_op), 32'(exp_op));
    chk("hold_addr", 32'(ex_addr), 32'(ins[13:9]));
    chk("hold_val1", 32'(ex_val1), 32'(ins[7:0]));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int acc;
    int pulses;
    int rets;
    int rdy_at;
    int c;
    logic [15:0] r_ins;

    rst = 1'b1;
    instr = 16'h0000;
    instr_valid = 1'b0;
    ex_ready = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_ready", 32'(instr_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ex_en", 32'(ex_en), 32'd0);
    chk("rst_retire", 32'(retire), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_timeout", 32'(err_timeout), 32'd0);
    chk("rst_fields", 32'({ex_op, ex_addr, ex_val1, ex_val2}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(instr_ready), 32'd1);

    // Reset in the middle of WAIT
    instr = 16'h4A00;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    chk("rw_ex_en", 32'(ex_en), 32'd1);
    note_en();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rw_outputs_zero",
        32'({instr_ready, busy, ex_en, retire, illegal, err_timeout, ex_op, ex_addr, ex_val1, ex_val2}),
        32'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rw_no_retire", 32'(retire), 32'd0);
      chk("rw_no_en", 32'(ex_en), 32'd0);
      if (i == 0) chk("rw_ready_after", 32'(instr_ready), 32'd1);
    end

    // Directed STORE: ready two cycles after ARM
    do_op(16'h8A5C, 2, lat);
    chk("store_latency6", 32'(lat), 32'd6);

    // LOAD while ex_ready is still high from the STORE
    do_op(16'h4600, 3, lat);
    chk("stale_latency7", 32'(lat), 32'd7);

    // NOP then illegal back-to-back
    do_op(16'h0000, 1, lat);
    do_op(16'hC000, 1, lat);
    chk("ill_after_nop", 32'(illegal), 32'd1);

    // Reserved bit set on a LOAD encoding
    do_op(16'h4100, 1, lat);

    // Timeout, then a normal STORE
    do_op(16'h4200, 100, lat);
    chk("timeout_latency20", 32'(lat), 32'd20);
    do_op(16'h9E77, 1, lat);
    chk("after_timeout_lat", 32'(lat), 32'd5);

    // Back-pressure: instr_valid held with four queued STOREs
    acc = 0; pulses = 0; rets = 0; rdy_at = -1; c = 0;
    instr = 16'h8C33;
    instr_valid = 1'b1;
    while (rets < 4 && c < 200) begin
      if (acc == 4) instr_valid = 1'b0;
      if (instr_valid && instr_ready) acc++;
      if (busy) chk("bp_ready_busy", 32'(instr_ready), 32'd0);
      @(negedge clk);
      c++;
      if (ex_en) begin
        pulses++;
        note_en();
        ex_ready = 1'b0;
        rdy_at = c + 3;
      end
      if (c == rdy_at) ex_ready = 1'b1;
      if (retire) rets++;
    end
    instr_valid = 1'b0;
    chk("bp_accepts", 32'(acc), 32'd4);
    chk("bp_pulses", 32'(pulses), 32'd4);
    chk("bp_retires", 32'(rets), 32'd4);

    // Randomized instructions against the transaction model
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      r_ins = 16'($urandom);
      r_ins[8] = ($urandom_range(0, 7) == 0);
      do_op(r_ins, int'($urandom_range(1, 20)), lat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
